vout_interp_rd: RTL
===================

# vout_interp_rd

Read-side companion to the frame-buffer write path in the scale-down pipeline. Accepts one output-pixel request at a time: a source coordinate plus four Q1.16 bilinear weights. It issues four neighbour reads into the frame buffer written by the input path, collects the returned RGB565 pixels, and performs per-channel weighted summation with rounding and saturation. The interpolated pixel is presented on a valid/ready output stream.

## Interface
- RD_LAT, 2, fixed frame-buffer read latency in cycles (≥1)
- vin_clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_sync_n  in  1  synchronous frame abort, active-low
- vin_xres  in  16  source width in pixels (≥1)
- vin_yres  in  16  source height in pixels (≥1)
- coo_valid  in  1  request valid
- coo_ready  out  1  request accepted when coo_valid & coo_ready
- coordinate_x  in  16  source x of top-left neighbour
- coordinate_y  in  16  source y of top-left neighbour
- coefficient1..coefficient4  in  17 each  Q1.16 weights for (x,y), (x+1,y), (x,y+1), (x+1,y+1)
- rd_en  out  1  read strobe; memory always accepts
- rd_addr  out  32  word address = y*vin_xres + x
- rd_dat  in  16  read data, valid exactly RD_LAT cycles after rd_en
- vout_valid  out  1  output pixel valid
- vout_ready  in  1  downstream accept
- vout_dat  out  16  RGB565 result

## Operation
- States: IDLE, RD, WAIT, CALC, OUT, FLUSH.
- coo_ready = (state==IDLE) & frame_sync_n.
- IDLE → RD on accept.
  - Latch the coefficients.
  - Clamp x to vin_xres-1 and y to vin_yres-1.
  - x1 = min(x+1, vin_xres-1); y1 = min(y+1, vin_yres-1).
  - Register the row bases y*vin_xres and y1*vin_xres (32-bit).
- RD: one rd_en per cycle for 4 cycles, addresses in the order (x,y), (x1,y), (x,y1), (x1,y1) → WAIT.
- WAIT: capture rd_dat into sample slot k on the k-th return, counted by a RD_LAT-delayed shift of rd_en. After the 4th capture → CALC.
- CALC: per channel (R[15:11], G[10:5], B[4:0]):
  - sum = Σ coef_i*ch_i (25-bit unsigned).
  - ch = (sum + 32768) >> 16, saturated to 31/63/31.
  - Register the result into vout_dat → OUT.
- OUT: vout_valid=1; vout_dat stable until vout_ready. On the handshake → IDLE.
- frame_sync_n low in any state:
  - Next state FLUSH; rd_en and vout_valid drop next cycle; sample slots discarded.
  - FLUSH holds while frame_sync_n low, then counts RD_LAT cycles with frame_sync_n high so stale returns are ignored → IDLE.
  - Abort from IDLE with no reads in flight still takes the FLUSH path.
- Weights summing to >65536 are legal; saturation handles them. No errors are flagged.

## Timing
- Reset values: coo_ready 0 until first cycle with rst_n high and frame_sync_n high (state IDLE); rd_en 0; rd_addr 0; vout_valid 0; vout_dat 0.
- Accept at cycle T: rd_en at T+1..T+4; returns at T+1+RD_LAT..T+4+RD_LAT; CALC at T+5+RD_LAT; vout_valid from T+6+RD_LAT (T+8 at default).
- Handshake at cycle H → coo_ready high at H+1; one request in flight maximum.
- rd_addr holds its last value when rd_en is low.
- vout_ready may be high before vout_valid. No combinational path from vout_ready to vout_valid.

## Structure
- Package scale_pkg holds:
  - state enum
  - Q16 constants (ONE=65536, HALF=32768)
  - RGB565 field positions and channel maxima
  - default RD_LAT
- One sub-module, scale_rgb565_mac: combinational 4-tap per-channel multiply, sum, round and saturate, registered by the parent in CALC.

## Test plan
- xres=yres=4, mem[a]=a+0x100; coo (1,2), coef1=65536, others 0 → rd_addr 9,10,13,14 at T+1..T+4; vout_dat=0x0109 at T+8.
- Pixels 0x0000, 0xFFFF, 0xFFFF, 0x0000, all coefs 16384 → vout_dat=0x8410.
- xres=yres=4, coo (3,3); also coo (7,9) → all four rd_addr=15 in both cases; vin_xres=1, coo (0,0) → addresses 0,0,xres-based row, same row.
- vout_ready low 5 cycles in OUT → vout_valid and vout_dat stable, coo_ready=0, rd_en=0; release → coo_ready=1 next cycle.
- frame_sync_n low 3 cycles during WAIT → no vout_valid for that request; coo_ready stays 0 for RD_LAT cycles after release; the next request then completes correctly.
- All coefs 65536, all pixels 0xFFFF → vout_dat=0xFFFF (saturated); all pixels 0x0000 → 0x0000.

Source files
------------

// File: rtl/scale_pkg.sv
// scale_pkg: shared FSM states, Q1.16 constants, RGB565 layout and default read latency
package scale_pkg;
  typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, OUT, FLUSH} state_e;
  localparam int ONE        = 65536;
  localparam int HALF       = 32768;
  localparam int R_LSB      = 11;
  localparam int G_LSB      = 5;
  localparam int B_LSB      = 0;
  localparam int R_MAX      = 31;
  localparam int G_MAX      = 63;
  localparam int B_MAX      = 31;
  localparam int RD_LAT_DEF = 2;
endpackage

// File: rtl/vout_interp_rd_if.sv
// vout_interp_rd_if: request, frame-buffer read and output-pixel buses
//   coo_*  : coordinate/weight request stream (valid/ready)
//   rd_*   : fixed-latency frame-buffer read port
//   vout_* : interpolated RGB565 output stream (valid/ready)
interface vout_interp_rd_if;
  logic        coo_valid;
  logic        coo_ready;
  logic [15:0] coordinate_x;
  logic [15:0] coordinate_y;
  logic [16:0] coefficient1;
  logic [16:0] coefficient2;
  logic [16:0] coefficient3;
  logic [16:0] coefficient4;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [15:0] rd_dat;
  logic        vout_valid;
  logic        vout_ready;
  logic [15:0] vout_dat;
  modport slave (
    input  coo_valid, coordinate_x, coordinate_y,
           coefficient1, coefficient2, coefficient3, coefficient4,
           rd_dat, vout_ready,
    output coo_ready, rd_en, rd_addr, vout_valid, vout_dat
  );
  modport master (
    output coo_valid, coordinate_x, coordinate_y,
           coefficient1, coefficient2, coefficient3, coefficient4,
           rd_dat, vout_ready,
    input  coo_ready, rd_en, rd_addr, vout_valid, vout_dat
  );
endinterface

// File: rtl/scale_rgb565_mac.sv
// scale_rgb565_mac: 4-tap Q1.16 weighted sum per RGB565 channel with rounding and saturation
//   coef : four Q1.16 weights, index 0 = top-left
//   pix  : four RGB565 neighbour pixels, same order as coef
//   dat  : interpolated RGB565 pixel (combinational)
module scale_rgb565_mac
  import scale_pkg::*;
(
  input  logic [3:0][16:0] coef,
  input  logic [3:0][15:0] pix,
  output logic [15:0]      dat
);
  // 17b weight x 6b channel x 4 taps plus rounding bias fits in 26 bits
  function automatic logic [5:0] chan(input logic [3:0][16:0] c, input logic [3:0][5:0] v, input logic [5:0] mx);
    logic [25:0] s;
    s = 26'(HALF);
    for (int i = 0; i < 4; i++) s = s + 26'(c[i]) * 26'(v[i]);
    return (s[25:16] > 10'(mx)) ? mx : s[21:16];
  endfunction
  logic [3:0][5:0] r, g, b;
  logic [5:0] rs, gs, bs;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r[i] = 6'(pix[i][R_LSB +: 5]);
      g[i] = pix[i][G_LSB +: 6];
      b[i] = 6'(pix[i][B_LSB +: 5]);
    end
  end
  assign rs  = chan(coef, r, 6'(R_MAX));
  assign gs  = chan(coef, g, 6'(G_MAX));
  assign bs  = chan(coef, b, 6'(B_MAX));
  assign dat = (16'(rs) << R_LSB) | (16'(gs) << G_LSB) | (16'(bs) << B_LSB);
endmodule

// File: rtl/vout_interp_rd.sv
// vout_interp_rd: bilinear read side - fetches four neighbours, blends them, streams one RGB565 pixel
//   vin_clk, rst_n        : clock, async active-low reset
//   frame_sync_n          : synchronous frame abort, active-low
//   vin_xres, vin_yres    : source frame size
//   bus (slave)           : request stream, frame-buffer read port, output stream
module vout_interp_rd
  import scale_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                    vin_clk,
  input  logic                    rst_n,
  input  logic                    frame_sync_n,
  input  logic [15:0]             vin_xres,
  input  logic [15:0]             vin_yres,
  vout_interp_rd_if.slave         bus
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d, k_q, k_d;
  logic [RD_LAT-1:0] sh_q, sh_d;
  logic [15:0] fcnt_q, fcnt_d, x0_q, x0_d, x1_q, x1_d;
  logic [31:0] base0_q, base0_d, base1_q, base1_d, rd_addr_q, rd_addr_d;
  logic [3:0][16:0] coef_q, coef_d;
  logic [3:0][15:0] pix_q, pix_d;
  logic [15:0] dat_q, dat_d, mac_dat;
  logic rd_en_q, rd_en_d;
  logic [15:0] xm, ym, cx, cy, cx1, cy1;
  assign xm  = vin_xres - 16'd1;
  assign ym  = vin_yres - 16'd1;
  assign cx  = (bus.coordinate_x > xm) ? xm : bus.coordinate_x;
  assign cy  = (bus.coordinate_y > ym) ? ym : bus.coordinate_y;
  assign cx1 = (cx == xm) ? xm : cx + 16'd1;
  assign cy1 = (cy == ym) ? ym : cy + 16'd1;
  scale_rgb565_mac u_mac (.coef(coef_q), .pix(pix_q), .dat(mac_dat));
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    fcnt_d    = fcnt_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    base0_d   = base0_q;
    base1_d   = base1_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    coef_d    = coef_q;
    pix_d     = pix_q;
    dat_d     = dat_q;
    // rd_en history: the top bit marks the cycle its read data is on rd_dat
    sh_d      = (sh_q << 1) | RD_LAT'(rd_en_q);
    if (!frame_sync_n) begin
      state_d = FLUSH;
      rd_en_d = 1'b0;
      k_d     = 2'd0;
      fcnt_d  = 16'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.coo_valid) begin
          state_d   = RD;
          coef_d    = {bus.coefficient4, bus.coefficient3, bus.coefficient2, bus.coefficient1};
          x0_d      = cx;
          x1_d      = cx1;
          base0_d   = 32'(cy) * 32'(vin_xres);
          base1_d   = 32'(cy1) * 32'(vin_xres);
          rd_en_d   = 1'b1;
          rd_addr_d = 32'(cy) * 32'(vin_xres) + 32'(cx);
          cnt_d     = 2'd0;
          k_d       = 2'd0;
        end
        RD: begin
          cnt_d     = cnt_q + 2'd1;
          rd_en_d   = cnt_q != 2'd3;
          rd_addr_d = cnt_q == 2'd0 ? base0_q + 32'(x1_q) :
                      cnt_q == 2'd1 ? base1_q + 32'(x0_q) :
                      cnt_q == 2'd2 ? base1_q + 32'(x1_q) : rd_addr_q;
          if (cnt_q == 2'd3) state_d = WAIT;
        end
        CALC: begin
          dat_d   = mac_dat;
          state_d = OUT;
        end
        OUT: if (bus.vout_ready) state_d = IDLE;
        FLUSH: begin
          fcnt_d = fcnt_q + 16'd1;
          if (fcnt_q == 16'(RD_LAT - 1)) begin
            state_d = IDLE;
            fcnt_d  = 16'd0;
          end
        end
        default: ;
      endcase
      // returns can start while reads are still being issued
      if ((state_q == RD || state_q == WAIT) && sh_q[RD_LAT-1]) begin
        pix_d[k_q] = bus.rd_dat;
        k_d        = k_q + 2'd1;
        if (k_q == 2'd3) state_d = CALC;
      end
    end
  end
  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      sh_q      <= '0;
      fcnt_q    <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      base0_q   <= '0;
      base1_q   <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      coef_q    <= '0;
      pix_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      sh_q      <= sh_d;
      fcnt_q    <= fcnt_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      base0_q   <= base0_d;
      base1_q   <= base1_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      coef_q    <= coef_d;
      pix_q     <= pix_d;
      dat_q     <= dat_d;
    end
  end
  assign bus.coo_ready  = rst_n && frame_sync_n && state_q == IDLE;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.vout_valid = state_q == OUT;
  assign bus.vout_dat   = dat_q;
endmodule
